// File: rtl/jesd204b_pkg.sv
// Shared JESD204B constants for the scrambler datapath: polynomial taps, state width,
// default seed and the TX/RX mode encoding.
package jesd204b_pkg;

   localparam int SCR_POLY_TAP_A = 14;
   localparam int SCR_POLY_TAP_B = 15;
   localparam int SCR_STATE_W    = 15;

   localparam logic [SCR_STATE_W-1:0] SCR_DEFAULT_SEED = 15'h7F80;

   typedef enum logic {
      SCR_MODE_TX = 1'b0,
      SCR_MODE_RX = 1'b1
   } scr_mode_e;

endpackage

// File: rtl/jesd204b_scr_lane.sv
// One lane of the 1+x^14+x^15 self-synchronous scrambler/descrambler, MSB first.
// Combinational data path plus the lane's 15-bit history register.
module jesd204b_scr_lane
   import jesd204b_pkg::*;
#(
   parameter int                      DATA_WIDTH = 32,
   parameter logic [SCR_STATE_W-1:0]  INIT_SEED  = SCR_DEFAULT_SEED
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   mode,
   input  logic                   seed_load,
   input  logic [SCR_STATE_W-1:0] seed_value,
   input  logic                   advance,
   input  logic [DATA_WIDTH-1:0]  d,
   output logic [DATA_WIDTH-1:0]  y
);

   logic [SCR_STATE_W-1:0] st_q;
   logic [SCR_STATE_W-1:0] st_d;
   logic [SCR_STATE_W-1:0] st_start;
   logic [SCR_STATE_W-1:0] st_walk;
   logic                   fb;
   logic                   in_bit;

   // A coincident seed load replaces the history before the beat is walked through it.
   always_comb begin
      st_start = seed_load ? seed_value : st_q;
      st_walk  = st_start;
      y        = d;
      fb       = 1'b0;
      in_bit   = 1'b0;
      if (en) begin
         for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb      = st_walk[SCR_POLY_TAP_B-1] ^ st_walk[SCR_POLY_TAP_A-1];
            y[i]    = d[i] ^ fb;
            in_bit  = (mode == SCR_MODE_RX) ? d[i] : y[i];
            st_walk = {st_walk[SCR_STATE_W-2:0], in_bit};
         end
      end
   end

   always_comb begin
      st_d = st_q;
      if (advance) begin
         st_d = st_walk;
      end else if (seed_load) begin
         st_d = seed_value;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q <= INIT_SEED;
      end else begin
         st_q <= st_d;
      end
   end

endmodule

// File: rtl/jesd204b_scrambler_mlane.sv
// Multi-lane JESD204B scrambler/descrambler with a valid/ready stream and a single
// registered output stage; each lane keeps its own independent history.
module jesd204b_scrambler_mlane
   import jesd204b_pkg::*;
#(
   parameter int                      LANES      = 4,
   parameter int                      DATA_WIDTH = 32,
   parameter logic [SCR_STATE_W-1:0]  INIT_SEED  = SCR_DEFAULT_SEED
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_en,
   input  logic                        cfg_mode,
   input  logic                        seed_load,
   input  logic [SCR_STATE_W-1:0]      seed_value,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [LANES*DATA_WIDTH-1:0] s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [LANES*DATA_WIDTH-1:0] m_data
);

   localparam int BUS_W = LANES * DATA_WIDTH;

   logic             m_valid_q;
   logic             m_valid_d;
   logic [BUS_W-1:0] m_data_q;
   logic [BUS_W-1:0] m_data_d;
   logic [BUS_W-1:0] lane_y;
   logic             accept;

   assign s_ready = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      jesd204b_scr_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .INIT_SEED  (INIT_SEED)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .en         (cfg_en),
         .mode       (cfg_mode),
         .seed_load  (seed_load),
         .seed_value (seed_value),
         .advance    (accept),
         .d          (s_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .y          (lane_y[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // The output register is the only storage: it refills on accept and empties on a take.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = lane_y;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;

endmodule
